// File: rtl/hwpe_ctrl_package.sv
// Shared definitions for the HWPE control path: reqrsp register indices,
// periph offsets with local LO/HI handling, and the bridge FSM state type.
package hwpe_ctrl_package;

  localparam logic [2:0] IDX_TRIGGER = 3'd0;
  localparam logic [2:0] IDX_STATUS  = 3'd1;
  localparam logic [2:0] IDX_JOBID   = 3'd2;
  localparam logic [2:0] IDX_SOFTCLR = 3'd3;
  localparam logic [2:0] IDX_PUSH    = 3'd4;
  localparam logic [2:0] IDX_PULL    = 3'd5;

  localparam logic [2:0] OFF_PUSH_LO = 3'd4;
  localparam logic [2:0] OFF_PUSH_HI = 3'd5;
  localparam logic [2:0] OFF_PULL_LO = 3'd6;
  localparam logic [2:0] OFF_PULL_HI = 3'd7;

  typedef enum logic [1:0] {
    BR_IDLE = 2'd0,
    BR_REQ  = 2'd1,
    BR_WAIT = 2'd2,
    BR_RESP = 2'd3
  } br_state_e;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/hwpe_ctrl_periph2reqrsp.sv
// 32-bit HWPE periph to 64-bit reqrsp bridge. One transaction in flight;
// PUSH is assembled from LO/HI halves here, PULL's upper half is buffered here.
module hwpe_ctrl_periph2reqrsp
  import hwpe_ctrl_package::*;
#(
  parameter int unsigned ID_WIDTH          = 8,
  parameter int unsigned PERIPH_DATA_WIDTH = 32,
  parameter int unsigned REQRSP_DATA_WIDTH = 64,
  parameter int unsigned REQRSP_ADDR_WIDTH = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         periph_req_i,
  output logic                         periph_gnt_o,
  input  logic [31:0]                  periph_add_i,
  input  logic                         periph_wen_i,
  input  logic [3:0]                   periph_be_i,
  input  logic [31:0]                  periph_data_i,
  input  logic [ID_WIDTH-1:0]          periph_id_i,
  output logic                         periph_r_valid_o,
  output logic [31:0]                  periph_r_data_o,
  output logic [ID_WIDTH-1:0]          periph_r_id_o,
  output logic                         reqrsp_q_valid_o,
  input  logic                         reqrsp_q_ready_i,
  output logic [REQRSP_ADDR_WIDTH-1:0] reqrsp_q_addr_o,
  output logic                         reqrsp_q_write_o,
  output logic [REQRSP_DATA_WIDTH-1:0] reqrsp_q_data_o,
  input  logic                         reqrsp_p_valid_i,
  output logic                         reqrsp_p_ready_o,
  input  logic [REQRSP_DATA_WIDTH-1:0] reqrsp_p_data_i
);

  if (PERIPH_DATA_WIDTH != 32) begin : g_chk_pw
    $error("PERIPH_DATA_WIDTH must be 32");
  end
  if (REQRSP_DATA_WIDTH != 2*PERIPH_DATA_WIDTH) begin : g_chk_rw
    $error("REQRSP_DATA_WIDTH must be 2*PERIPH_DATA_WIDTH");
  end

  br_state_e                    state_q, state_d;
  logic [31:0]                  push_lo_q, push_lo_d, pull_hi_q, pull_hi_d;
  logic                         hi_valid_q, hi_valid_d, pull_lo_q, pull_lo_d;
  logic                         r_valid_q, r_valid_d;
  logic [31:0]                  r_data_q, r_data_d;
  logic [ID_WIDTH-1:0]          r_id_q, r_id_d;
  logic                         q_valid_q, q_valid_d, q_write_q, q_write_d;
  logic [REQRSP_ADDR_WIDTH-1:0] q_addr_q, q_addr_d;
  logic [REQRSP_DATA_WIDTH-1:0] q_data_q, q_data_d;

  logic [2:0]  off, idx;
  logic        is_rd, is_local;
  logic [31:0] mask;
  logic        unused_add;

  assign unused_add   = ^{periph_add_i[31:5], periph_add_i[1:0]};
  assign off          = periph_add_i[4:2];
  assign is_rd        = periph_wen_i;
  // offsets 4 and 7 never leave the bridge, whatever the direction
  assign is_local     = (off == OFF_PUSH_LO) || (off == OFF_PULL_HI);
  assign mask         = be_mask(periph_be_i);
  assign periph_gnt_o = periph_req_i && (state_q == BR_IDLE);

  always_comb begin
    case (off)
      OFF_PUSH_HI: idx = IDX_PUSH;
      OFF_PULL_LO: idx = IDX_PULL;
      default:     idx = off;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    push_lo_d  = push_lo_q;
    pull_hi_d  = pull_hi_q;
    hi_valid_d = hi_valid_q;
    pull_lo_d  = pull_lo_q;
    r_valid_d  = r_valid_q;
    r_data_d   = r_data_q;
    r_id_d     = r_id_q;
    q_valid_d  = q_valid_q;
    q_write_d  = q_write_q;
    q_addr_d   = q_addr_q;
    q_data_d   = q_data_q;
    case (state_q)
      BR_IDLE: if (periph_gnt_o) begin
        r_id_d = periph_id_i;
        if (is_local) begin
          state_d   = BR_RESP;
          r_valid_d = 1'b1;
          r_data_d  = '0;
          if (!is_rd && off == OFF_PUSH_LO)
            push_lo_d = (push_lo_q & ~mask) | (periph_data_i & mask);
          if (is_rd && off == OFF_PULL_HI) begin
            r_data_d   = hi_valid_q ? pull_hi_q : '0;
            hi_valid_d = 1'b0;
          end
        end else begin
          state_d       = BR_REQ;
          q_valid_d     = 1'b1;
          q_write_d     = !is_rd;
          q_addr_d      = '0;
          q_addr_d[4:2] = idx;
          q_data_d      = is_rd ? '0 : {32'b0, periph_data_i};
          pull_lo_d     = is_rd && (off == OFF_PULL_LO);
          if (!is_rd && off == OFF_PUSH_HI) begin
            q_data_d  = {periph_data_i & mask, push_lo_q};
            push_lo_d = '0;
          end
        end
      end
      BR_REQ: if (reqrsp_q_ready_i) begin
        q_valid_d = 1'b0;
        if (q_write_q) begin
          state_d   = BR_RESP;
          r_valid_d = 1'b1;
          r_data_d  = '0;
        end else begin
          state_d = BR_WAIT;
        end
      end
      BR_WAIT: if (reqrsp_p_valid_i) begin
        state_d   = BR_RESP;
        r_valid_d = 1'b1;
        r_data_d  = reqrsp_p_data_i[31:0];
        if (pull_lo_q) begin
          pull_hi_d  = reqrsp_p_data_i[63:32];
          hi_valid_d = 1'b1;
        end
      end
      BR_RESP: begin
        state_d   = BR_IDLE;
        r_valid_d = 1'b0;
      end
      default: state_d = BR_IDLE;
    endcase
    // clear only scrubs staging state; the FSM still completes its response
    if (clear_i) begin
      push_lo_d  = '0;
      pull_hi_d  = '0;
      hi_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BR_IDLE;
      push_lo_q  <= '0;
      pull_hi_q  <= '0;
      hi_valid_q <= 1'b0;
      pull_lo_q  <= 1'b0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_id_q     <= '0;
      q_valid_q  <= 1'b0;
      q_write_q  <= 1'b0;
      q_addr_q   <= '0;
      q_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      push_lo_q  <= push_lo_d;
      pull_hi_q  <= pull_hi_d;
      hi_valid_q <= hi_valid_d;
      pull_lo_q  <= pull_lo_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      r_id_q     <= r_id_d;
      q_valid_q  <= q_valid_d;
      q_write_q  <= q_write_d;
      q_addr_q   <= q_addr_d;
      q_data_q   <= q_data_d;
    end
  end

  assign periph_r_valid_o = r_valid_q;
  assign periph_r_data_o  = r_data_q;
  assign periph_r_id_o    = r_id_q;
  assign reqrsp_q_valid_o = q_valid_q;
  assign reqrsp_q_addr_o  = q_addr_q;
  assign reqrsp_q_write_o = q_write_q;
  assign reqrsp_q_data_o  = q_data_q;
  assign reqrsp_p_ready_o = 1'b1;

endmodule

// File: doc/hwpe_ctrl_periph2reqrsp.md
Name: hwpe_ctrl_periph2reqrsp

Overview:
Upstream bridge in front of the Snitch-style reqrsp control target. It accepts 32-bit HWPE peripheral (req/gnt + r_valid) accesses from a cluster interconnect and turns them into 64-bit reqrsp requests on the target's register indices. PUSH and PULL are split into LO/HI 32-bit halves: PUSH is assembled locally, and the upper half of a PULL response is buffered. Only one transaction is outstanding at a time, and the FSM serialises them.

Parameters:
ID_WIDTH, 8, periph transaction ID width
PERIPH_DATA_WIDTH, 32, periph data width (fixed 32; checked by elaboration assertion)
REQRSP_DATA_WIDTH, 64, reqrsp data width (fixed 2*PERIPH_DATA_WIDTH)
REQRSP_ADDR_WIDTH, 32, reqrsp address width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous clear of staging/buffer state (driven by target clear_o)
periph_req_i  in  1  request valid
periph_gnt_o  out  1  request grant
periph_add_i  in  32  byte address; only bits [4:2] decoded
periph_wen_i  in  1  1=read, 0=write (periph convention)
periph_be_i  in  4  byte enables
periph_data_i  in  32  write data
periph_id_i  in  ID_WIDTH  transaction ID
periph_r_valid_o  out  1  response valid (reads and writes)
periph_r_data_o  out  32  read data
periph_r_id_o  out  ID_WIDTH  echoed ID
reqrsp_q_valid_o  out  1  request valid
reqrsp_q_ready_i  in  1  request ready
reqrsp_q_addr_o  out  REQRSP_ADDR_WIDTH  register index in bits [4:2], other bits 0
reqrsp_q_write_o  out  1  write
reqrsp_q_data_o  out  REQRSP_DATA_WIDTH  write data
reqrsp_p_valid_i  in  1  response valid
reqrsp_p_ready_o  out  1  response ready (tied 1)
reqrsp_p_data_i  in  REQRSP_DATA_WIDTH  response data

Behaviour:
- Reset is asynchronous, active-low, on rst_ni; clock is clk_i. On reset all registered outputs are 0: r_valid, r_data, r_id, q_valid, q_addr, q_write, q_data. FSM resets to IDLE; push_lo staging, pull_hi buffer and hi_valid reset to 0.
- Periph offset decode on add[4:2]:
  - 0 TRIGGER→idx0; 1 STATUS→idx1; 2 JOBID→idx2; 3 SOFTCLR→idx3.
  - 4 PUSH_LO (local); 5 PUSH_HI→idx4; 6 PULL_LO→idx5; 7 PULL_HI (local).
- periph_gnt_o = periph_req_i & (state==IDLE). This is combinational; the accept cycle is t.
- FSM states: IDLE, REQ, WAIT, RESP.
  - IDLE→REQ on accept of a forwarded access. q_* are registered at t and valid from t+1.
  - IDLE→RESP on a local access (PUSH_LO write, PULL_HI read, writes to 7, reads of 4).
  - REQ holds q_valid and payload stable until q_ready. Then a write goes to RESP and a read goes to WAIT; q_valid drops the cycle after the handshake.
  - WAIT→RESP on p_valid.
  - RESP→IDLE unconditionally; r_valid=1 for exactly that one cycle, with r_id = latched ID.
- Latency with q_ready=1 and the target's 1-cycle response:
  - local: r_valid at t+1.
  - forwarded write: r_valid at t+2.
  - forwarded read: r_valid at t+3.
- Forwarded write data is {32'b0, wdata}; be is ignored. A SOFTCLR with wdata==0 stays all-zero downstream.
- PUSH_LO write merges wdata into push_lo under be. PUSH_HI write sends {wdata masked-merged with 0 by be, push_lo}, then clears push_lo to 0.
- Forwarded read returns p_data[31:0]. PULL_LO additionally captures p_data[63:32] into pull_hi and sets hi_valid.
- PULL_HI read returns pull_hi if hi_valid, else 0, and clears hi_valid.
- Write responses and reads of write-only offsets return r_data=0.
- p_valid seen outside WAIT is dropped (p_ready stays 1).
- clear_i resets push_lo, pull_hi and hi_valid only. It does not touch the FSM, so an in-flight SOFTCLR still completes its r_valid. If clear_i and a local update land in the same cycle, clear wins.
- periph_req_i held while busy is not granted; there is no ordering hazard because only one transaction is in flight.

Decomposition:
- Shared package hwpe_ctrl_package gets:
  - localparams for the reqrsp indices (TRIGGER..PULL, 0..5);
  - periph offsets PUSH_LO/PUSH_HI/PULL_LO/PULL_HI;
  - the bridge FSM state enum typedef.
- No sub-module; the LO/HI split logic stays inline.
- Integration wrapper: hwpe_ctrl_periph2reqrsp feeding hwpe_ctrl_reqrsp_target.

Test Plan:
- Reset mid-REQ (q_valid=1, q_ready=0), assert rst_ni=0 → q_valid and r_valid go 0 asynchronously; after release, gnt returns on the next req.
- PUSH_LO write 0xDEADBEEF, then PUSH_HI write 0x01234567 → a single reqrsp write to idx4 with data 0x01234567_DEADBEEF; two r_valid pulses with r_data=0 and correct IDs.
- PULL_LO read, target returns 0xAAAA5555_12345678 → r_data=0x12345678 at t+3.
  - Then PULL_HI read → r_data=0xAAAA5555 at t+1.
  - A second PULL_HI → 0.
- Write TRIGGER with q_ready held low 3 cycles → q_valid stable 4 cycles and gnt=0 throughout; r_valid exactly 1 cycle after the handshake.
- STATUS read while busy, target returns 1 → r_data=1 with r_id echoed. Back-to-back periph reqs are each granted only from IDLE.
- SOFTCLR write with data 0 plus clear_i pulse during RESP → r_valid still delivered; push_lo and hi_valid cleared.
